// File: rtl/cozy_uart.sv
// Memory-mapped 8N1 UART responder for the cozy CPU data bus.
// Answers loads/stores with RAM timing; TX FIFO feeds a shifter, RX lands in a one-byte holding register.
module cozy_uart #(
  parameter logic [15:0] BASE        = 16'hff00,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int unsigned TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_addr,
  input  logic [1:0]  mem_bwe,
  input  logic [15:0] mem_dout,
  output logic [15:0] mem_din,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned AW = $clog2(TX_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ---------------------------------------------------------------- decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       data_wr;
  logic       data_rd;
  logic       stat_wr;
  logic       div_sel;
  logic       addr_lane_unused;

  assign hit              = (mem_addr[15:3] == BASE[15:3]);
  assign reg_sel          = mem_addr[2:1];
  assign data_wr          = hit && (reg_sel == 2'd0) && mem_bwe[0];
  assign data_rd          = hit && (reg_sel == 2'd0) && (mem_bwe == 2'b00);
  assign stat_wr          = hit && (reg_sel == 2'd1) && mem_bwe[0];
  assign div_sel          = hit && (reg_sel == 2'd2);
  assign addr_lane_unused = mem_addr[0];

  // ---------------------------------------------------------------- divisor
  logic [15:0] div;
  logic [15:0] div_eff;

  assign div_eff = (div < 16'd2) ? 16'd2 : div;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div <= DEFAULT_DIV;
    end else if (div_sel) begin
      if (mem_bwe[0]) div[7:0]  <= mem_dout[7:0];
      if (mem_bwe[1]) div[15:8] <= mem_dout[15:8];
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        tx_pop;
  logic        push_ok;
  logic [7:0]  fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = data_wr && (!fifo_full || tx_pop);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= mem_dout[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- transmitter
  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [15:0] tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_pop  = !fifo_empty &&
                   ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_tick));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_state <= ST_START;
            tx_shift <= fifo_head;
            tx_div   <= div_eff;
            tx_cnt   <= div_eff - 16'd1;
            uart_tx  <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_tick) begin
            tx_state <= ST_DATA;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= tx_div - 16'd1;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_tick) begin
            tx_cnt <= tx_div - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              uart_tx  <= 1'b1;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          if (tx_tick) begin
            if (tx_pop) begin
              // Back-to-back frame: next start bit follows the stop bit with no idle gap.
              tx_state <= ST_START;
              tx_shift <= fifo_head;
              tx_div   <= div_eff;
              tx_cnt   <= div_eff - 16'd1;
              uart_tx  <= 1'b0;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receiver
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [15:0] rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_done;

  assign rx_tick = (rx_cnt == 16'd0);
  assign rx_done = (rx_state == ST_STOP) && rx_tick && rx_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DEFAULT_DIV;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= ST_START;
            rx_div   <= div_eff;
            rx_cnt   <= (div_eff >> 1) - 16'd1;
          end
        end
        ST_START: begin
          if (rx_tick) begin
            if (rx_s2) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_state <= ST_DATA;
              rx_bit   <= '0;
              rx_cnt   <= rx_div - 16'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= rx_div - 16'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_tick) rx_state <= ST_IDLE;
          else         rx_cnt   <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- holding register and flags
  logic       rxv;
  logic       overrun;
  logic       txdrop;
  logic [7:0] rxbyte;
  logic       rx_pop;

  assign rx_pop = data_rd && rxv;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rxv     <= 1'b0;
      overrun <= 1'b0;
      rxbyte  <= '0;
    end else begin
      if (stat_wr && mem_dout[4]) overrun <= 1'b0;
      // A byte arriving alongside a CPU pop wins and is not an overrun.
      if (rx_done) begin
        rxbyte <= rx_shift;
        rxv    <= 1'b1;
        if (rxv && !rx_pop) overrun <= 1'b1;
      end else if (rx_pop) begin
        rxv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      txdrop <= 1'b0;
    end else if (data_wr && !push_ok) begin
      txdrop <= 1'b1;
    end else if (stat_wr && mem_dout[5]) begin
      txdrop <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- read data
  logic [15:0] status;

  assign status = {10'b0, txdrop, overrun, rxv, (tx_state != ST_IDLE), fifo_empty, fifo_full};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_din <= '0;
    end else if (hit) begin
      case (reg_sel)
        2'd0:    mem_din <= {rxv, 7'b0, rxbyte};
        2'd1:    mem_din <= status;
        2'd2:    mem_din <= div;
        default: mem_din <= '0;
      endcase
    end else begin
      mem_din <= '0;
    end
  end

endmodule
